// File: rtl/bin_to_gray_pkg.sv
// -----------------------------------------------------------------------------
// bin_to_gray_pkg
//   Shared definitions for the binary/Gray converter:
//     MODE_B2G / MODE_G2B : encodings of the 'mode' input
//     MAX_WIDTH           : widest code the popcount helper accepts
//     popcount()          : number of set bits in a zero-extended vector
// -----------------------------------------------------------------------------
package bin_to_gray_pkg;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  // Callers zero-extend their operand to this width before counting.
  localparam int MAX_WIDTH = 64;

  function automatic logic [7:0] popcount(input logic [MAX_WIDTH-1:0] v);
    logic [7:0] cnt;
    cnt = 8'd0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      cnt = cnt + 8'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/bin_to_gray_gray_codec.sv
// -----------------------------------------------------------------------------
// gray_codec
//   Purely combinational code converter.
//   Ports:
//     x    in  [WIDTH-1:0]  operand (binary for MODE_B2G, Gray for MODE_G2B)
//     mode in  1            MODE_B2G or MODE_G2B
//     y    out [WIDTH-1:0]  converted value
// -----------------------------------------------------------------------------
module gray_codec
  import bin_to_gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic             mode,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] b2g;
  logic [WIDTH-1:0] g2b;

  assign b2g = x ^ (x >> 1);

  // Binary bit i is the XOR of all Gray bits from the MSB down to i. Written
  // as a prefix XOR per bit so there is no bit-to-bit chain inside one vector.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_g2b
      assign g2b[gi] = ^x[WIDTH-1:gi];
    end
  endgenerate

  assign y = (mode == MODE_G2B) ? g2b : b2g;

endmodule

// File: rtl/bin_to_gray.sv
// -----------------------------------------------------------------------------
// bin_to_gray
//   Binary-to-Gray converter with a zero-latency combinational output, a
//   registered bidirectional conversion path and a Gray step-distance checker.
//   Ports:
//     clk       in   rising-edge clock
//     rst       in   asynchronous active-high reset
//     a         in   [WIDTH-1:0] operand (binary if mode=0, Gray if mode=1)
//     mode      in   0 = bin->Gray, 1 = Gray->bin (registered path only)
//     in_valid  in   qualifies a/mode for the registered path
//     c         out  [WIDTH-1:0] combinational Gray of a (ignores mode)
//     q         out  [WIDTH-1:0] registered conversion result
//     out_valid out  q carries a new result this cycle
//     adj_err   out  pulse with out_valid: Gray step distance was > 1
// -----------------------------------------------------------------------------
module bin_to_gray
  import bin_to_gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             mode,
  input  logic             in_valid,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] q,
  output logic             out_valid,
  output logic             adj_err
);

  logic [WIDTH-1:0] conv;

  logic [WIDTH-1:0] q_q, q_d;
  logic             out_valid_q, out_valid_d;
  logic             adj_err_q, adj_err_d;
  logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
  logic             have_prev_q, have_prev_d;

  // Combinational output: always binary -> Gray.
  gray_codec #(.WIDTH(WIDTH)) u_codec_c (
    .x    (a),
    .mode (MODE_B2G),
    .y    (c)
  );

  // Registered path: direction chosen by mode.
  gray_codec #(.WIDTH(WIDTH)) u_codec_reg (
    .x    (a),
    .mode (mode),
    .y    (conv)
  );

  always_comb begin
    q_d         = q_q;
    out_valid_d = 1'b0;
    adj_err_d   = 1'b0;
    prev_gray_d = prev_gray_q;
    have_prev_d = have_prev_q;

    if (in_valid) begin
      q_d         = conv;
      out_valid_d = 1'b1;
      // Only bin->Gray samples feed the step checker; conv is the new Gray code.
      if (mode == MODE_B2G) begin
        if (have_prev_q &&
            (popcount(MAX_WIDTH'(conv ^ prev_gray_q)) > 8'd1)) begin
          adj_err_d = 1'b1;
        end
        prev_gray_d = conv;
        have_prev_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q         <= '0;
      out_valid_q <= 1'b0;
      adj_err_q   <= 1'b0;
      prev_gray_q <= '0;
      have_prev_q <= 1'b0;
    end else begin
      q_q         <= q_d;
      out_valid_q <= out_valid_d;
      adj_err_q   <= adj_err_d;
      prev_gray_q <= prev_gray_d;
      have_prev_q <= have_prev_d;
    end
  end

  assign q         = q_q;
  assign out_valid = out_valid_q;
  assign adj_err   = adj_err_q;

endmodule

// File: tb/tb_bin_to_gray.sv
module tb_bin_to_gray;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic       mode;
  logic       in_valid;
  logic [3:0] c;
  logic [3:0] q;
  logic       out_valid;
  logic       adj_err;

  int n_cmp;
  int n_bad;

  bin_to_gray #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .mode      (mode),
    .in_valid  (in_valid),
    .c         (c),
    .q         (q),
    .out_valid (out_valid),
    .adj_err   (adj_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic       mode;
    logic       vld;
    logic [3:0] exp_c;
    logic [3:0] exp_q;
    logic       exp_ov;
    logic       exp_err;
  } vec_t;

  vec_t vecs [0:31];
  int   n_vecs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] av, input logic m, input logic v,
                     input logic [3:0] ec, input logic [3:0] eq,
                     input logic eov, input logic eerr);
    vecs[n_vecs] = '{av, m, v, ec, eq, eov, eerr};
    n_vecs++;
  endtask

  initial begin
    logic [3:0] gray_tab [0:15];
    n_cmp = 0;
    n_bad = 0;
    n_vecs = 0;

    gray_tab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    // Registered mode=0 stream 0..15 then wrap to 0: no step errors.
    for (int i = 0; i < 16; i++) add(4'(i), 1'b0, 1'b1, gray_tab[i], gray_tab[i], 1'b1, 1'b0);
    add(4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0);
    // Gray->binary; c stays bin->Gray of a. prev_gray must stay 0000.
    add(4'h8, 1'b1, 1'b1, 4'hC, 4'hF, 1'b1, 1'b0);
    add(4'h6, 1'b1, 1'b1, 4'h5, 4'h4, 1'b1, 1'b0);
    // a=1 (0001) is distance 1 from 0000, but >1 from any mode=1 leftover.
    add(4'h1, 1'b0, 1'b1, 4'h1, 4'h1, 1'b1, 1'b0);
    add(4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0);
    add(4'h3, 1'b0, 1'b1, 4'h2, 4'h2, 1'b1, 1'b0);
    add(4'h5, 1'b0, 1'b1, 4'h7, 4'h7, 1'b1, 1'b1);  // 0010 -> 0111: distance 2
    add(4'h5, 1'b0, 1'b1, 4'h7, 4'h7, 1'b1, 1'b0);  // repeat: distance 0, pulse gone
    // Idle: c tracks a, q holds, out_valid low.
    add(4'hA, 1'b0, 1'b0, 4'hF, 4'h7, 1'b0, 1'b0);
    add(4'h3, 1'b1, 1'b0, 4'h2, 4'h7, 1'b0, 1'b0);
    add(4'hE, 1'b0, 1'b0, 4'h9, 4'h7, 1'b0, 1'b0);

    // Reset state.
    rst = 1'b1;
    a = 4'h0;
    mode = 1'b0;
    in_valid = 1'b0;
    #12;
    check("reset_q", 32'(q), 32'h0);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_adj_err", 32'(adj_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < n_vecs; i++) begin
      @(negedge clk);
      a = vecs[i].a;
      mode = vecs[i].mode;
      in_valid = vecs[i].vld;
      #1;
      check($sformatf("v%0d_c", i), 32'(c), 32'(vecs[i].exp_c));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("v%0d_adj_err", i), 32'(adj_err), 32'(vecs[i].exp_err));
      $display("vec %0d: a=%h mode=%0d vld=%0d -> c=%h q=%h ov=%0d err=%0d",
               i, a, mode, in_valid, c, q, out_valid, adj_err);
    end

    // Mid-stream reset: a=12 (1010) vs prev 0111 flags, then reset clears it.
    @(negedge clk);
    a = 4'hC; mode = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_q", 32'(q), 32'hA);
    check("pre_rst_adj_err", 32'(adj_err), 32'h1);
    $display("seq rst: pre-reset q=%h ov=%0d err=%0d", q, out_valid, adj_err);
    #2;
    rst = 1'b1;   // asynchronous: outputs clear without a clock edge
    #1;
    check("async_rst_q", 32'(q), 32'h0);
    check("async_rst_out_valid", 32'(out_valid), 32'h0);
    check("async_rst_adj_err", 32'(adj_err), 32'h0);
    // in_valid stays high across an edge while reset is held: reset wins.
    @(posedge clk);
    #1;
    check("rst_wins_q", 32'(q), 32'h0);
    check("rst_wins_out_valid", 32'(out_valid), 32'h0);
    $display("seq rst: during reset q=%h ov=%0d err=%0d", q, out_valid, adj_err);
    @(negedge clk);
    rst = 1'b0;
    a = 4'h9;     // Gray 1101: distance 3 from 1010, but first after reset
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_q", 32'(q), 32'hD);
    check("post_rst_out_valid", 32'(out_valid), 32'h1);
    check("post_rst_adj_err", 32'(adj_err), 32'h0);
    $display("seq rst: first after release q=%h ov=%0d err=%0d", q, out_valid, adj_err);
    // Checker re-armed: 9 -> 6 is 1101 -> 0101, distance 1; 6 -> 10 is 0101 -> 1111, distance 2.
    @(negedge clk);
    a = 4'h6;
    @(posedge clk);
    #1;
    check("rearm_legal_adj_err", 32'(adj_err), 32'h0);
    @(negedge clk);
    a = 4'hA;
    @(posedge clk);
    #1;
    check("rearm_q", 32'(q), 32'hF);
    check("rearm_adj_err", 32'(adj_err), 32'h1);
    $display("seq rearm: q=%h ov=%0d err=%0d", q, out_valid, adj_err);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("idle_out_valid", 32'(out_valid), 32'h0);
    check("idle_adj_err", 32'(adj_err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
